// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Arbitrates the single register-file write port between the in-order
//   pipeline write-back stage and a multi-cycle unit (mult/div). The pipeline
//   normally has priority. An optional starvation guard stalls the pipeline
//   for one grant once the multi-cycle result has waited MAX_WAIT cycles.
//
//   Optional feature macro: WB_STARVE_GUARD_EN
//     defined   : wait counter + NORM/FORCE_M FSM, pipe_stall driven
//     undefined : strict pipeline priority, pipe_stall tied 0
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   p_valid           pipeline write-back request
//   p_mem_to_reg      1: p_read_data, 0: p_alu_result
//   p_read_data       load data
//   p_alu_result      ALU result
//   p_rd              pipeline destination register
//   m_valid/m_rd/m_data  multi-cycle request, held until m_ready
//   m_ready           multi-cycle request accepted this cycle (comb)
//   pipe_stall        freeze pipeline (p_* held while high)
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
module wb_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4  // 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_valid,
  input  logic        p_mem_to_reg,
  input  logic [31:0] p_read_data,
  input  logic [31:0] p_alu_result,
  input  logic [4:0]  p_rd,
  input  logic        m_valid,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_data,
  output logic        m_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t p_req, m_req, win;
  logic    grant_p, grant_m, grant;

  assign p_req.rd   = p_rd;
  assign p_req.data = p_mem_to_reg ? p_read_data : p_alu_result;
  assign m_req.rd   = m_rd;
  assign m_req.data = m_data;

`ifdef WB_STARVE_GUARD_EN
  typedef enum logic {NORM, FORCE_M} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORM;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_p      = 1'b0;
    grant_m      = 1'b0;
    pipe_stall   = 1'b0;
    wait_cnt_nxt = '0;
    case (state)
      NORM: begin
        grant_p = p_valid;
        grant_m = !p_valid && m_valid;
      end
      FORCE_M: begin
        pipe_stall = 1'b1;
        grant_m    = m_valid;
      end
      default: ;
    endcase
    // Reset masks the handshake so a pending m request is not consumed
    // while the write port is held in reset.
    m_ready = rst_n && grant_m;

    // Counter only measures a continuously denied request.
    if (m_valid && !m_ready)
      wait_cnt_nxt = (wait_cnt == 4'hF) ? 4'hF : wait_cnt + 4'd1;

    case (state)
      NORM:    if (m_valid && !m_ready && wait_cnt == WAIT_LAST) state_nxt = FORCE_M;
      FORCE_M: if (!m_valid || m_ready) state_nxt = NORM;
      default: state_nxt = NORM;
    endcase
  end
`else
  // Strict pipeline priority: m waits as long as p_valid stays high.
  assign grant_p    = p_valid;
  assign grant_m    = !p_valid && m_valid;
  assign m_ready    = rst_n && grant_m;
  assign pipe_stall = 1'b0;
`endif

  assign grant = grant_p || grant_m;
  assign win   = grant_p ? p_req : m_req;

  // Write port: one-cycle pulse per grant. Destination x0 completes the
  // handshake but never writes. Address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant && (win.rd != 5'd0);
      if (grant) begin
        rf_waddr <= win.rd;
        rf_wdata <= win.data;
      end
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: consecutive cycles a pending multi-cycle result may be denied before forced grant; legal range 1..15.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 p_valid  in  1  pipeline write-back request.
REQ-005 p_mem_to_reg  in  1  1 selects p_read_data, 0 selects p_alu_result.
REQ-006 p_read_data  in  32  load data from memory stage.
REQ-007 p_alu_result  in  32  ALU result.
REQ-008 p_rd  in  5  pipeline destination register.
REQ-009 m_valid  in  1  multi-cycle unit (mult/div) result request; held until handshake.
REQ-010 m_rd  in  5  multi-cycle destination register.
REQ-011 m_data  in  32  multi-cycle result.
REQ-012 m_ready  out  1  multi-cycle request accepted this cycle (combinational).
REQ-013 pipe_stall  out  1  freeze pipeline; p_* inputs held stable while high.
REQ-014 rf_we  out  1  register-file write enable, registered.
REQ-015 rf_waddr  out  5  register-file write address, registered.
REQ-016 rf_wdata  out  32  register-file write data, registered.

Function
REQ-017 Pipeline write data SHALL be p_read_data when p_mem_to_reg=1, else p_alu_result.
REQ-018 Exactly one request SHALL be granted per cycle; a grant in cycle N SHALL drive rf_we/rf_waddr/rf_wdata in cycle N+1 for exactly one cycle.
REQ-019 FSM states: NORM, FORCE_M.
REQ-020 NORM: p_valid=1 grants pipeline; else m_valid=1 grants multi-cycle unit (m_ready=1); pipe_stall=0.
REQ-021 FORCE_M: pipe_stall=1; pipeline never granted; m_valid=1 grants multi-cycle unit.
REQ-022 Wait counter (4 bits) SHALL increment each cycle m_valid=1 and m_ready=0, clear when m_ready=1 or m_valid=0, saturate at 15.
REQ-023 NORM->FORCE_M at the clock edge where m_valid=1, m_ready=0 and counter value before the edge equals MAX_WAIT-1.
REQ-024 FORCE_M->NORM at the edge after m_valid&m_ready, or at any edge with m_valid=0.
REQ-025 Granted request with destination 0 SHALL complete its handshake but leave rf_we=0 next cycle.
REQ-026 No grant in cycle N SHALL give rf_we=0 in N+1; rf_waddr/rf_wdata hold last values.
REQ-027 A denied m request SHALL NOT be lost; m_valid/m_rd/m_data held by source until m_ready.

Reset
REQ-028 rst_n low SHALL immediately force state NORM, counter 0, rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0.
REQ-029 m_ready SHALL be 0 while rst_n low; an ungranted m request pending at reset SHALL be granted normally after release.
REQ-030 First grant possible in the first cycle with rst_n high; rf_we earliest in the following cycle.

Configuration
REQ-031 Macro WB_STARVE_GUARD_EN defined: counter, FORCE_M state and pipe_stall behave per REQ-021..REQ-024.
REQ-032 Macro WB_STARVE_GUARD_EN undefined: no counter or FORCE_M; strict pipeline priority; pipe_stall tied 0; m request waits indefinitely while p_valid=1.

Verification
REQ-033 p_valid=1, p_mem_to_reg=1, p_read_data=1, p_alu_result=2, p_rd=3 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=1; repeat with p_mem_to_reg=0 -> rf_wdata=2.
REQ-034 p_valid=0, m_valid=1, m_rd=7, m_data=0xDEADBEEF -> same cycle m_ready=1; next cycle rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF.
REQ-035 Guard on, MAX_WAIT=4, p_valid and m_valid held 1 -> pipeline granted 4 cycles, pipe_stall=1 in cycle 5, m_ready=1 in cycle 5, pipe_stall=0 in cycle 6.
REQ-036 Guard off, same stimulus for 20 cycles -> m_ready=0 and pipe_stall=0 throughout.
REQ-037 p_valid=1, p_rd=0, p_alu_result=0x55 -> handshake completes, rf_we=0 next cycle.
REQ-038 rst_n low in FORCE_M with m_valid=1 -> pipe_stall=0, rf_we=0, m_ready=0 immediately; after release with p_valid=0 -> m_ready=1 first cycle.
